// File: rtl/exe_unit_seq.sv
// Sequential execution unit: add/sub finish in the accepting cycle, mul/mulh
// iterate a shift-add loop for WIDTH cycles. One operation in flight at a time.
module exe_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic                 high_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        count_reg;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_next;

  assign in_ready = (state_reg == IDLE);

  // The top bit of the (WIDTH+1)-bit difference is set exactly when a < b.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    addend   = '0;
    if (mplier_reg[count_reg])
      addend = {{WIDTH{1'b0}}, mcand_reg} << count_reg;
    acc_next = acc_reg + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      flag       <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      high_reg   <= 1'b0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (!op[1]) begin
              result    <= op[0] ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
              flag      <= op[0] ? diff[WIDTH] : sum[WIDTH];
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              mcand_reg  <= a;
              mplier_reg <= b;
              high_reg   <= op[0];
              acc_reg    <= '0;
              count_reg  <= '0;
              state_reg  <= MUL;
            end
          end
        end
        MUL: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + 1'b1;
          // Final step: take the result from acc_next so this cycle's add counts.
          if (count_reg == CW'(WIDTH-1)) begin
            result    <= high_reg ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
            flag      <= |acc_next[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
